// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_pkg : shared CPU types and constants for hazard control. Rev 1.0
// ============================================================================
package hazard_ctrl_pkg;

   localparam int CPU_AW = 6;
   localparam int LD_CW  = 2;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LDWAIT  = 2'd1,
      ST_MULWAIT = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic              valid;
      logic [CPU_AW-1:0] rd;
      logic              wb_en;
      logic              is_load;
      logic              is_mul;
   } trk_entry_t;

   // x0 is hard-wired, so an entry targeting it can never supply a value
   function automatic logic rd_hit(input trk_entry_t e,
                                   input logic [CPU_AW-1:0] src,
                                   input logic used);
      return used && e.valid && e.wb_en && (e.rd != '0) && (e.rd == src);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_track.sv
`default_nettype none
// ============================================================================
// hazard_track : in-flight destination tracker and forwarding selector. Rev 1.0
// ============================================================================
module hazard_track
   import hazard_ctrl_pkg::*;
#(
   parameter int NSTG = 2,
   parameter int AW   = CPU_AW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       advance,
   input  logic                       in_valid,
   input  logic [AW-1:0]              in_rd,
   input  logic                       in_wb_en,
   input  logic                       in_is_load,
   input  logic                       in_is_mul,
   input  logic [AW-1:0]              rs1,
   input  logic [AW-1:0]              rs2,
   input  logic                       rs1_used,
   input  logic                       rs2_used,
   output logic                       ld_hit,
   output logic [$clog2(NSTG+1)-1:0]  sel1,
   output logic [$clog2(NSTG+1)-1:0]  sel2
);

   localparam int SW = $clog2(NSTG+1);

   trk_entry_t ent [1:NSTG];
   trk_entry_t ent_in;

   always_comb begin
      ent_in = '0;
      if (in_valid) begin
         ent_in.valid   = 1'b1;
         ent_in.rd      = CPU_AW'(in_rd);
         ent_in.wb_en   = in_wb_en;
         ent_in.is_load = in_is_load;
         ent_in.is_mul  = in_is_mul;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 1; k <= NSTG; k++) ent[k] <= '0;
      end else if (advance) begin
         ent[1] <= ent_in;
         for (int k = 2; k <= NSTG; k++) ent[k] <= ent[k-1];
      end
   end

   // Walk oldest to youngest so the youngest match is the one left standing
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      for (int k = NSTG; k >= 1; k--) begin
         if (rd_hit(ent[k], CPU_AW'(rs1), rs1_used)) sel1 = SW'(k);
         if (rd_hit(ent[k], CPU_AW'(rs2), rs2_used)) sel2 = SW'(k);
      end
   end

   assign ld_hit = ent[1].is_load &&
                   (rd_hit(ent[1], CPU_AW'(rs1), rs1_used) ||
                    rd_hit(ent[1], CPU_AW'(rs2), rs2_used));

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : load-use / multiply interlock and operand forwarding. Rev 1.0
// ============================================================================
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int AW       = CPU_AW,
   parameter int NSTG     = 2,
   parameter int LD_STALL = 1,
   parameter int MUL_LAT  = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bus_stall,
   input  logic                       flush,
   input  logic                       id_valid,
   input  logic                       id_is_load,
   input  logic                       id_is_mul,
   input  logic                       id_wb_en,
   input  logic [AW-1:0]              id_rs1,
   input  logic [AW-1:0]              id_rs2,
   input  logic [AW-1:0]              id_rd,
   input  logic                       id_rs1_used,
   input  logic                       id_rs2_used,
   input  logic [AW-1:0]              wb_rd,
   input  logic                       wb_en,
   output logic                       stall_id,
   output logic                       bubble_ex,
   output logic [$clog2(NSTG+1)-1:0]  fwd1_sel,
   output logic [$clog2(NSTG+1)-1:0]  fwd2_sel,
   output logic                       rf_byp1,
   output logic                       rf_byp2,
   output logic                       mul_busy
);

   localparam int SW = $clog2(NSTG+1);
   localparam int MW = $clog2(MUL_LAT);

   hz_state_t         state, state_nxt;
   logic [LD_CW-1:0]  ld_cnt, ld_cnt_nxt;
   logic [MW-1:0]     mul_cnt, mul_cnt_nxt;
   logic [AW-1:0]     mul_rd;
   logic              mul_rd_vld;
   logic              ld_hit, ld_haz, mul_dep, mul_haz, mul_acc;
   logic              trk_valid, stall_nxt, bubble_nxt;
   logic [SW-1:0]     sel1, sel2;

   assign trk_valid = id_valid && !bubble_ex && !flush;

   hazard_track #(
      .NSTG (NSTG),
      .AW   (AW)
   ) u_track (
      .clk        (clk),
      .rst        (rst),
      .advance    (!bus_stall),
      .in_valid   (trk_valid),
      .in_rd      (id_rd),
      .in_wb_en   (id_wb_en),
      .in_is_load (id_is_load),
      .in_is_mul  (id_is_mul),
      .rs1        (id_rs1),
      .rs2        (id_rs2),
      .rs1_used   (id_rs1_used),
      .rs2_used   (id_rs2_used),
      .ld_hit     (ld_hit),
      .sel1       (sel1),
      .sel2       (sel2)
   );

   assign rf_byp1 = wb_en && (wb_rd != '0) && (wb_rd == id_rs1);
   assign rf_byp2 = wb_en && (wb_rd != '0) && (wb_rd == id_rs2);

   assign ld_haz  = id_valid && ld_hit;
   assign mul_dep = mul_rd_vld &&
                    ((id_rs1_used && (id_rs1 == mul_rd)) ||
                     (id_rs2_used && (id_rs2 == mul_rd)));
   assign mul_haz = id_valid && mul_busy && (id_is_mul || mul_dep);
   assign mul_acc = (state == ST_IDLE) && !flush && id_valid && id_is_mul &&
                    !ld_haz && !mul_haz;

   always_comb begin
      state_nxt   = state;
      ld_cnt_nxt  = ld_cnt;
      mul_cnt_nxt = (mul_cnt != '0) ? mul_cnt - MW'(1) : mul_cnt;
      if (mul_acc) mul_cnt_nxt = MW'(MUL_LAT - 1);

      case (state)
         ST_IDLE: begin
            if (ld_haz) begin
               state_nxt  = ST_LDWAIT;
               ld_cnt_nxt = LD_CW'(LD_STALL);
            end else if (mul_haz) begin
               state_nxt  = ST_MULWAIT;
            end
         end
         ST_LDWAIT: begin
            ld_cnt_nxt = (ld_cnt != '0) ? ld_cnt - LD_CW'(1) : '0;
            if (ld_cnt_nxt == '0) state_nxt = ST_IDLE;
         end
         // Exit is judged on the current busy flag, so the last busy cycle still stalls
         ST_MULWAIT: begin
            if (!mul_haz) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (flush) begin
         state_nxt  = ST_IDLE;
         ld_cnt_nxt = '0;
      end

      stall_nxt  = !flush && (state_nxt != ST_IDLE);
      bubble_nxt = flush || (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         ld_cnt     <= '0;
         mul_cnt    <= '0;
         mul_busy   <= 1'b0;
         mul_rd     <= '0;
         mul_rd_vld <= 1'b0;
         stall_id   <= 1'b0;
         bubble_ex  <= 1'b0;
         fwd1_sel   <= '0;
         fwd2_sel   <= '0;
      end else if (!bus_stall) begin
         state     <= state_nxt;
         ld_cnt    <= ld_cnt_nxt;
         mul_cnt   <= mul_cnt_nxt;
         mul_busy  <= (mul_cnt_nxt != '0);
         stall_id  <= stall_nxt;
         bubble_ex <= bubble_nxt;
         fwd1_sel  <= sel1;
         fwd2_sel  <= sel2;
         if (mul_acc) begin
            mul_rd     <= id_rd;
            mul_rd_vld <= id_wb_en && (id_rd != '0);
         end
      end
   end

endmodule
`default_nettype wire
